dac_serial_writer: RTL
======================

// Module: dac_serial_writer
// PURPOSE
//  Serial DAC write controller, upstream of the DAC readback error checker.
//  Takes a parallel word, shifts it MSB-first on dac_din with dac_sclk/dac_sync_n.
//  Generates the checker's controls: dac_sclr pulses once per transaction, and
//  dac_cmp_en strobes once per bit at the point where dac_din and dac_dout are aligned.
// PARAMETERS
//  DATA_W   24  DAC word length in bits (also DAC shift-register depth); 2..32
//  CLK_DIV  2   clk cycles per dac_sclk half-period; >=1
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       asynchronous, active-low reset
//  start       in   1       request write; accepted only when ready=1
//  abort       in   1       synchronous abort of a transaction in progress
//  wr_data     in   DATA_W  word to write, latched on the accept cycle
//  ready       out  1       1 in IDLE only
//  busy        out  1       1 from the cycle after accept until done
//  done        out  1       1-clk pulse at normal end of transaction
//  dac_sclk    out  1       serial clock, idles high
//  dac_sync_n  out  1       frame select, active low, idles high
//  dac_din     out  1       serial data to DAC (also to checker dac_din)
//  dac_sclr    out  1       1-clk clear pulse to checker
//  dac_cmp_en  out  1       1-clk compare strobe to checker
// BEHAVIOUR
//  Reset: ready=1; busy=0; done=0; dac_sclk=1; dac_sync_n=1; dac_din=0;
//   dac_sclr=0; dac_cmp_en=0; FSM in IDLE. Reset mid-frame aborts the frame immediately.
//  FSM: IDLE -> LEAD -> SHIFT -> TAIL -> IDLE.
//   IDLE: start=1 accepts the transaction and latches wr_data (cycle A).
//   LEAD (cycle A+1, CLK_DIV clks): sync_n=0, sclk=1, din=MSB. dac_sclr=1 for its first clk only.
//   SHIFT: NBITS bits. Each bit is a low phase of CLK_DIV clks, then a high phase of CLK_DIV clks.
//    The falling sclk edge at the start of the low phase is the DAC sample point.
//    The next bit is driven on din at the start of the following high phase.
//    The first bit's high phase is LEAD.
//   TAIL (CLK_DIV clks): sclk=1, sync_n=0, din holds last bit.
//    Then sync_n=1, done=1 for 1 clk, busy=0, IDLE.
//   sync_n low duration = NBITS*2*CLK_DIV + CLK_DIV clks; ready=1 again on the cycle after done.
//  Counters: divider counts 0..CLK_DIV-1; bit counter counts 0..NBITS-1 and does not wrap mid-frame.
//  start while busy: ignored, no queuing. start and abort together in IDLE: abort wins, nothing accepted.
//  abort in LEAD/SHIFT/TAIL: next clk sync_n=1, sclk=1, din=0, cmp_en=0, IDLE; done NOT pulsed.
//  dac_cmp_en: asserted on the first clk of a low phase, only for bits counted as compare bits
//   (see CONFIGURATION). Without the feature it is never asserted.
//  dac_sclr: exactly one pulse per accepted transaction; it is also emitted when the transaction is later aborted.
// CONFIGURATION
//  Macro DAC_READBACK_EN.
//  Defined: NBITS = 2*DATA_W. The latched word is shifted twice in one frame.
//   During bits DATA_W..2*DATA_W-1 the DAC's SDO (dac_dout) returns word 1 while din carries word 2.
//   dac_cmp_en pulses on each of these DATA_W low phases, so a healthy DAC gives dac_din==dac_dout at every strobe.
//  Undefined: NBITS = DATA_W, single shift, dac_cmp_en tied 0, dac_sclr still pulses.
// TESTING  (DATA_W=24, CLK_DIV=2)
//  1 reset low mid-SHIFT -> all outputs at reset values within the same cycle (async); no done.
//  2 start, wr_data=24'hA5C3F0, feature off -> sync_n low for 98 clks.
//    Falling-edge din samples = A5C3F0 MSB-first; 24 falls; one sclr at frame start; done 1 clk after sync_n rises.
//  3 same with DAC_READBACK_EN -> sync_n low for 194 clks; 48 falls; exactly 24 cmp_en pulses, first at fall 25.
//    A DAC model echoing with 24-bit delay gives din==dout at every strobe.
//  4 start held continuously for 400 clks -> back-to-back frames.
//    Each new frame is accepted only on a cycle with ready=1; there is at least 1 idle clk with sync_n=1 between frames.
//  5 abort at bit 10 of SHIFT -> next clk sync_n=1, sclk=1, din=0; no done; ready=1.
//    A new start then latches the new wr_data.
//  6 start asserted together with abort in IDLE -> no transaction; sync_n stays 1; no sclr.

Source files
------------

// File: rtl/dac_serial_writer.sv
`default_nettype none
// ============================================================================
//  Module      : dac_serial_writer
//  Description : Serial DAC write controller. Shifts a latched parallel word
//                MSB-first on dac_din, framed by dac_sync_n and clocked by
//                dac_sclk. Also generates the clear pulse (dac_sclr) and the
//                per-bit compare strobe (dac_cmp_en) for the readback checker.
//  Options     : DAC_READBACK_EN - shift the word twice per frame and strobe
//                dac_cmp_en on the second pass, when the DAC's SDO echoes
//                the first pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_serial_writer #(
    parameter int DATA_W  = 24,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              dac_sclk,
    output logic              dac_sync_n,
    output logic              dac_din,
    output logic              dac_sclr,
    output logic              dac_cmp_en
);

`ifdef DAC_READBACK_EN
    localparam int NBITS = 2 * DATA_W;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int BIT_W = $clog2(NBITS);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(NBITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TAIL  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                phase_q, phase_d;   // 0 = sclk low phase, 1 = high phase
    logic [DATA_W-1:0]   shreg_q, shreg_d;

    logic                div_end;
    logic                in_frame;

    assign div_end  = (div_q == LAST_DIV);
    assign in_frame = (state_q == S_LEAD) || (state_q == S_SHIFT) || (state_q == S_TAIL);

    // State, counters and shift register; reset kills any frame at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            shreg_q <= shreg_d;
        end
    end

    // Next-state: frame sequencing, divider and bit counting
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        shreg_d = shreg_q;

        case (state_q)
            S_IDLE: begin
                // abort beats start when both arrive together
                if (start && !abort) begin
                    state_d = S_LEAD;
                    shreg_d = wr_data;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end
            end

            S_LEAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else if (div_end) begin
                    state_d = S_SHIFT;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_SHIFT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                    bit_d   = '0;
                    phase_d = 1'b0;
                end else if (div_end) begin
                    div_d = '0;
                    if (!phase_q) begin
                        // End of a low phase: last bit goes to TAIL, otherwise
                        // rise sclk and present the next bit (rotation lets the
                        // readback build re-send the same word).
                        if (bit_q == LAST_BIT) begin
                            state_d = S_TAIL;
                        end else begin
                            phase_d = 1'b1;
                            shreg_d = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
                        end
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_TAIL: begin
                if (abort) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else if (div_end) begin
                    state_d = S_DONE;
                    div_d   = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                bit_d   = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    // Outputs decoded from registered state (Moore)
    always_comb begin
        ready      = (state_q == S_IDLE);
        busy       = in_frame;
        done       = (state_q == S_DONE);
        dac_sync_n = !in_frame;
        dac_sclk   = !((state_q == S_SHIFT) && !phase_q);
        dac_din    = in_frame ? shreg_q[DATA_W-1] : 1'b0;
        dac_sclr   = (state_q == S_LEAD) && (div_q == '0);
`ifdef DAC_READBACK_EN
        // Second pass only: SDO now carries the first pass back
        dac_cmp_en = (state_q == S_SHIFT) && !phase_q && (div_q == '0)
                     && (bit_q >= BIT_W'(DATA_W));
`else
        dac_cmp_en = 1'b0;
`endif
    end

endmodule
`default_nettype wire
